rob_retire: RTL and testbench
=============================

// Module: rob_retire
// PURPOSE
//  In-order retirement end of the rename pipeline. A circular reorder buffer takes one renamed instr/cycle
//  (rd, new pd, previous mapping old_pd) and marks entries done on execution completion. It retires the
//  oldest done entry each cycle: commit reported to architectural RAT, old_pd handed back to the rename
//  free pool. Sits between rename/dispatch and the physical-register free pool.
// PARAMETERS
//  DEPTH   16  ROB entries; power of 2, >=2. IDX_W = $clog2(DEPTH) (localparam)
//  PREG_W  6   physical register index width (64 pregs)
//  AREG_W  5   architectural register index width
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       async active-low reset
//  alloc_valid   in   1       rename presents an instr
//  alloc_ready   out  1       entry free; alloc accepted when alloc_valid & alloc_ready
//  alloc_rd      in   AREG_W  arch dest reg; 0 = no destination
//  alloc_pd      in   PREG_W  newly allocated preg for rd
//  alloc_old_pd  in   PREG_W  preg previously mapped to rd in RAT
//  alloc_tag     out  IDX_W   ROB index given to this instr (= tail), combinational
//  cmpl_valid    in   1       execution completion strobe
//  cmpl_tag      in   IDX_W   ROB index that completed
//  commit_valid  out  1       one-cycle pulse per retired entry
//  commit_rd     out  AREG_W  rd of retired entry
//  commit_pd     out  PREG_W  pd of retired entry
//  free_valid    out  1       old_pd available for free pool
//  free_preg     out  PREG_W  preg being released
//  free_ready    in   1       free pool accepts free_preg
//  rob_count     out  IDX_W+1 occupied entries
// BEHAVIOUR
//  Reset (async, rst_n=0): head=tail=0, rob_count=0, all entry valid/done cleared, commit_valid=0,
//   commit_rd=0, commit_pd=0, free_valid=0, free_preg=0; alloc_ready=1 once rst_n deasserted.
//   Reset mid-operation discards all entries and any pending free; nothing is emitted for them.
//  Alloc: alloc_ready = (rob_count != DEPTH), from registered count only. On accept: entry[tail] <=
//   {valid=1,done=0,rd,pd,old_pd}; tail <= tail+1 mod DEPTH. Full: no accept even if a retire fires.
//  Complete: cmpl_valid sets entry[cmpl_tag].done at the next edge. Tag of an invalid entry: ignored.
//   Repeat completion of a done entry: no effect.
//  Retire: fires at an edge when entry[head].valid & done & !(free_valid & !free_ready). On retire:
//   entry[head].valid<=0, head<=head+1 mod DEPTH; commit_valid<=1 with commit_rd/pd for 1 cycle.
//   rd!=0: free_valid<=1, free_preg<=old_pd. rd==0: commit pulses, no free issued.
//   Max one retire/cycle; strictly in order, done entries behind a not-done head wait.
//  Free handshake: free_valid/free_preg held stable until free_valid & free_ready at an edge; then
//   cleared unless a new retire loads it the same edge (back-to-back frees allowed when free_ready=1).
//  Latency: cmpl in cycle c on head entry -> commit_valid (and free_valid) high in cycle c+2.
//  Count: rob_count += accept - retire each edge; simultaneous alloc+retire leaves it unchanged.
//   Alloc into an index freed the same edge is not possible (full blocks alloc).
//  Pointers: IDX_W bits, wrap naturally; count disambiguates full/empty.
//  commit_* registered; when commit_valid=0 commit_rd/pd hold last value (don't care).
// TESTING
//  1 Reset: rst_n=0 mid-run with 5 valid entries -> all outputs 0, rob_count=0, no commit/free follows.
//  2 Alloc rd=3,pd=40,old=7 tag0; cmpl tag0 cycle c -> cycle c+2 commit{3,40}, free_preg=7, count 0.
//  3 Out-of-order: alloc tags 0,1,2; complete 2,1,0 -> commits in order 0,1,2 on consecutive cycles.
//  4 Fill 16 -> alloc_ready=0, 17th held; complete head -> next edge count 15, ready=1, tail wrapped to 0.
//  5 free_ready=0 for 4 cycles, two done entries -> free_preg stable, retire stalls; release -> both freed.
//  6 rd=0 entry (pd=0) retires -> commit_valid pulses with commit_rd=0; free_valid stays 0.

Source files
------------

// File: rtl/rob_retire.sv
// Reorder buffer retirement end: allocates renamed instructions in order, marks them done on
// completion, retires the oldest done entry per cycle and hands its old physical register back.
module rob_retire #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 6,
    parameter int AREG_W = 5,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [AREG_W-1:0] alloc_rd,
    input  logic [PREG_W-1:0] alloc_pd,
    input  logic [PREG_W-1:0] alloc_old_pd,
    output logic [IDX_W-1:0]  alloc_tag,

    input  logic              cmpl_valid,
    input  logic [IDX_W-1:0]  cmpl_tag,

    output logic              commit_valid,
    output logic [AREG_W-1:0] commit_rd,
    output logic [PREG_W-1:0] commit_pd,

    output logic              free_valid,
    output logic [PREG_W-1:0] free_preg,
    input  logic              free_ready,

    output logic [IDX_W:0]    rob_count
);

    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] PTR_ONE    = IDX_W'(1);

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_done;
    logic [AREG_W-1:0] ent_rd     [DEPTH];
    logic [PREG_W-1:0] ent_pd     [DEPTH];
    logic [PREG_W-1:0] ent_old_pd [DEPTH];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;

    logic accept;
    logic free_stall;
    logic retire;
    logic head_has_dest;

    // Handshakes: a transfer happens at a rising edge where valid & ready are both high.
    // A producer holds valid and its payload stable until that edge; ready never depends on valid.
    assign alloc_ready   = (count != FULL_COUNT);
    assign accept        = alloc_valid & alloc_ready;
    assign alloc_tag     = tail;
    assign rob_count     = count;

    // A pending free that the pool has not taken blocks retirement so free_preg never changes under it.
    assign free_stall    = free_valid & ~free_ready;
    assign retire        = ent_valid[head] & ent_done[head] & ~free_stall;
    assign head_has_dest = (ent_rd[head] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            if (accept) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
            end
            // The tail slot is never valid when accepting, so a completion cannot race an allocation.
            if (cmpl_valid && ent_valid[cmpl_tag]) begin
                ent_done[cmpl_tag] <= 1'b1;
            end
            if (retire) begin
                ent_valid[head] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ent_rd[tail]     <= alloc_rd;
            ent_pd[tail]     <= alloc_pd;
            ent_old_pd[tail] <= alloc_old_pd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                tail <= tail + PTR_ONE;
            end
            if (retire) begin
                head <= head + PTR_ONE;
            end
            count <= count + (IDX_W + 1)'(accept) - (IDX_W + 1)'(retire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_pd    <= '0;
        end else begin
            commit_valid <= retire;
            if (retire) begin
                commit_rd <= ent_rd[head];
                commit_pd <= ent_pd[head];
            end
        end
    end

    // A retire with a destination reloads the free slot on the same edge the old value is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_valid <= 1'b0;
            free_preg  <= '0;
        end else if (retire && head_has_dest) begin
            free_valid <= 1'b1;
            free_preg  <= ent_old_pd[head];
        end else if (free_valid && free_ready) begin
            free_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: queue-based reference model checked every cycle, plus
// hand-computed commit/free sequences and literal checks for each scenario.
module tb_rob_retire;

    localparam int DEPTH  = 16;
    localparam int PREG_W = 6;
    localparam int AREG_W = 5;
    localparam int IDX_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [AREG_W-1:0] alloc_rd;
    logic [PREG_W-1:0] alloc_pd;
    logic [PREG_W-1:0] alloc_old_pd;
    logic [IDX_W-1:0]  alloc_tag;
    logic              cmpl_valid;
    logic [IDX_W-1:0]  cmpl_tag;
    logic              commit_valid;
    logic [AREG_W-1:0] commit_rd;
    logic [PREG_W-1:0] commit_pd;
    logic              free_valid;
    logic [PREG_W-1:0] free_preg;
    logic              free_ready;
    logic [IDX_W:0]    rob_count;

    rob_retire #(.DEPTH(DEPTH), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_rd     (alloc_rd),
        .alloc_pd     (alloc_pd),
        .alloc_old_pd (alloc_old_pd),
        .alloc_tag    (alloc_tag),
        .cmpl_valid   (cmpl_valid),
        .cmpl_tag     (cmpl_tag),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_pd    (commit_pd),
        .free_valid   (free_valid),
        .free_preg    (free_preg),
        .free_ready   (free_ready),
        .rob_count    (rob_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time exceeded 50000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hand-computed scoreboards: {rd,pd} of every commit and every preg handed to the pool.
    logic [AREG_W+PREG_W-1:0] exp_q[$];
    logic [PREG_W-1:0]        free_exp_q[$];

    // Reference model: program-order list of in-flight instructions.
    typedef struct {
        logic [AREG_W-1:0] rd;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] old;
        logic [IDX_W-1:0]  tag;
        logic              done;
    } m_ent_t;

    m_ent_t            m_q[$];
    logic [IDX_W-1:0]  m_next_tag;
    logic              m_cv;
    logic [AREG_W-1:0] m_crd;
    logic [PREG_W-1:0] m_cpd;
    logic              m_fv;
    logic [PREG_W-1:0] m_fp;
    logic              last_fv;
    logic [PREG_W-1:0] last_fp;

    task automatic model_step();
        m_ent_t ent;
        logic   ret;
        logic   acc;
        ret = 1'b0;
        if (m_q.size() > 0) ret = m_q[0].done && !(m_fv && !free_ready);
        acc = alloc_valid && (m_q.size() < DEPTH);
        if (cmpl_valid) begin
            foreach (m_q[i]) if (m_q[i].tag == cmpl_tag) m_q[i].done = 1'b1;
        end
        m_cv = ret;
        if (ret) begin
            ent   = m_q.pop_front();
            m_crd = ent.rd;
            m_cpd = ent.pd;
            if (ent.rd != 0) begin
                m_fv = 1'b1;
                m_fp = ent.old;
            end else if (m_fv && free_ready) begin
                m_fv = 1'b0;
            end
        end else if (m_fv && free_ready) begin
            m_fv = 1'b0;
        end
        if (acc) begin
            ent.rd   = alloc_rd;
            ent.pd   = alloc_pd;
            ent.old  = alloc_old_pd;
            ent.tag  = m_next_tag;
            ent.done = 1'b0;
            m_q.push_back(ent);
            m_next_tag = m_next_tag + 1'b1;
        end
    endtask

    task automatic compare();
        chk("alloc_ready", 32'(alloc_ready), 32'(m_q.size() != DEPTH));
        chk("alloc_tag", 32'(alloc_tag), 32'(m_next_tag));
        chk("rob_count", 32'(rob_count), 32'(m_q.size()));
        chk("commit_valid", 32'(commit_valid), 32'(m_cv));
        if (m_cv) begin
            chk("commit_rd", 32'(commit_rd), 32'(m_crd));
            chk("commit_pd", 32'(commit_pd), 32'(m_cpd));
        end
        chk("free_valid", 32'(free_valid), 32'(m_fv));
        if (m_fv) chk("free_preg", 32'(free_preg), 32'(m_fp));
        if (commit_valid) begin
            chk("commit_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("commit_order", 32'({commit_rd, commit_pd}), 32'(exp_q.pop_front()));
        end
        last_fv = free_valid;
        last_fp = free_preg;
    endtask

    always begin
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_next_tag = '0;
            m_cv  = 1'b0;
            m_crd = '0;
            m_cpd = '0;
            m_fv  = 1'b0;
            m_fp  = '0;
        end else begin
            if (last_fv && free_ready) begin
                chk("free_expected", 32'(free_exp_q.size() != 0), 32'd1);
                if (free_exp_q.size() != 0) chk("free_order", 32'(last_fp), 32'(free_exp_q.pop_front()));
            end
            model_step();
        end
        #1;
        compare();
    end

    // ---------------- driver tasks (entered just after a falling edge) ----------------
    task automatic cycle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic alloc(input logic [AREG_W-1:0] rd, input logic [PREG_W-1:0] pd,
                         input logic [PREG_W-1:0] old);
        alloc_valid  = 1'b1;
        alloc_rd     = rd;
        alloc_pd     = pd;
        alloc_old_pd = old;
        @(negedge clk);
        alloc_valid  = 1'b0;
    endtask

    task automatic cmpl(input logic [IDX_W-1:0] tag);
        cmpl_valid = 1'b1;
        cmpl_tag   = tag;
        @(negedge clk);
        cmpl_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [AREG_W-1:0] rd, input logic [PREG_W-1:0] pd);
        exp_q.push_back({rd, pd});
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_commit_rd", 32'(commit_rd), 32'd0);
        chk("rst_commit_pd", 32'(commit_pd), 32'd0);
        chk("rst_free_valid", 32'(free_valid), 32'd0);
        chk("rst_free_preg", 32'(free_preg), 32'd0);
        chk("rst_rob_count", 32'(rob_count), 32'd0);
        chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_rd     = '0;
        alloc_pd     = '0;
        alloc_old_pd = '0;
        cmpl_valid   = 1'b0;
        cmpl_tag     = '0;
        free_ready   = 1'b1;
        last_fv      = 1'b0;
        last_fp      = '0;
        @(negedge clk);
        reset_dut();

        // Single instruction, completion-to-commit latency of two cycles.
        alloc(5'd3, 6'd40, 6'd7);
        push_exp(5'd3, 6'd40);
        free_exp_q.push_back(6'd7);
        cmpl(4'd0);
        chk("t2_no_early_commit", 32'(commit_valid), 32'd0);
        cycle(1);
        chk("t2_commit_valid", 32'(commit_valid), 32'd1);
        chk("t2_commit_rd", 32'(commit_rd), 32'd3);
        chk("t2_commit_pd", 32'(commit_pd), 32'd40);
        chk("t2_free_valid", 32'(free_valid), 32'd1);
        chk("t2_free_preg", 32'(free_preg), 32'd7);
        chk("t2_count", 32'(rob_count), 32'd0);
        cycle(1);
        chk("t2_pulse_end", 32'(commit_valid), 32'd0);
        chk("t2_free_taken", 32'(free_valid), 32'd0);

        // Out-of-order completion retires in program order.
        reset_dut();
        alloc(5'd1, 6'd10, 6'd20);
        alloc(5'd2, 6'd11, 6'd21);
        alloc(5'd4, 6'd12, 6'd22);
        push_exp(5'd1, 6'd10); push_exp(5'd2, 6'd11); push_exp(5'd4, 6'd12);
        free_exp_q.push_back(6'd20); free_exp_q.push_back(6'd21); free_exp_q.push_back(6'd22);
        cmpl(4'd2);
        cmpl(4'd1);
        chk("t3_head_blocks", 32'(commit_valid), 32'd0);
        chk("t3_count3", 32'(rob_count), 32'd3);
        cmpl(4'd0);
        cycle(1);
        chk("t3_c0_rd", 32'(commit_rd), 32'd1);
        chk("t3_c0_valid", 32'(commit_valid), 32'd1);
        cycle(1);
        chk("t3_c1_rd", 32'(commit_rd), 32'd2);
        chk("t3_c1_preg", 32'(free_preg), 32'd21);
        cycle(1);
        chk("t3_c2_pd", 32'(commit_pd), 32'd12);
        chk("t3_c2_valid", 32'(commit_valid), 32'd1);
        cycle(1);
        chk("t3_done", 32'(commit_valid), 32'd0);
        chk("t3_empty", 32'(rob_count), 32'd0);

        // rd=0 commits without releasing a register.
        reset_dut();
        alloc(5'd9, 6'd21, 6'd5);
        alloc(5'd0, 6'd0, 6'd0);
        push_exp(5'd9, 6'd21); push_exp(5'd0, 6'd0);
        free_exp_q.push_back(6'd5);
        cmpl(4'd0);
        cmpl(4'd1);
        chk("t6_first_rd", 32'(commit_rd), 32'd9);
        chk("t6_first_free", 32'(free_preg), 32'd5);
        cycle(1);
        chk("t6_commit_valid", 32'(commit_valid), 32'd1);
        chk("t6_commit_rd0", 32'(commit_rd), 32'd0);
        chk("t6_commit_pd0", 32'(commit_pd), 32'd0);
        chk("t6_no_free", 32'(free_valid), 32'd0);

        // Free pool back-pressure stalls retirement and holds free_preg.
        reset_dut();
        free_ready = 1'b0;
        alloc(5'd5, 6'd30, 6'd50);
        alloc(5'd6, 6'd31, 6'd51);
        push_exp(5'd5, 6'd30); push_exp(5'd6, 6'd31);
        free_exp_q.push_back(6'd50); free_exp_q.push_back(6'd51);
        cmpl(4'd0);
        cmpl(4'd1);
        chk("t5_first_commit", 32'(commit_rd), 32'd5);
        chk("t5_free_preg", 32'(free_preg), 32'd50);
        for (int i = 0; i < 4; i++) begin
            cycle(1);
            chk("t5_hold_valid", 32'(free_valid), 32'd1);
            chk("t5_hold_preg", 32'(free_preg), 32'd50);
            chk("t5_stall_count", 32'(rob_count), 32'd1);
            chk("t5_stall_commit", 32'(commit_valid), 32'd0);
        end
        free_ready = 1'b1;
        cycle(1);
        chk("t5_second_commit", 32'(commit_rd), 32'd6);
        chk("t5_back_to_back", 32'(free_valid), 32'd1);
        chk("t5_second_preg", 32'(free_preg), 32'd51);
        chk("t5_count0", 32'(rob_count), 32'd0);
        cycle(1);
        chk("t5_free_clear", 32'(free_valid), 32'd0);

        // Fill to full, hold a 17th request, retire the head, pointer wrap.
        reset_dut();
        for (int i = 0; i < DEPTH; i++) begin
            alloc(5'(i + 1), 6'(32 + i), 6'(20 + i));
        end
        chk("t4_full_ready", 32'(alloc_ready), 32'd0);
        chk("t4_full_count", 32'(rob_count), 32'd16);
        chk("t4_tail_wrap", 32'(alloc_tag), 32'd0);
        push_exp(5'd1, 6'd32);
        free_exp_q.push_back(6'd20);
        alloc_valid  = 1'b1;
        alloc_rd     = 5'd17;
        alloc_pd     = 6'd60;
        alloc_old_pd = 6'd61;
        cmpl_valid   = 1'b1;
        cmpl_tag     = 4'd0;
        cycle(1);
        cmpl_valid   = 1'b0;
        chk("t4_held_count", 32'(rob_count), 32'd16);
        chk("t4_held_ready", 32'(alloc_ready), 32'd0);
        cycle(1);
        chk("t4_retire_count", 32'(rob_count), 32'd15);
        chk("t4_retire_ready", 32'(alloc_ready), 32'd1);
        chk("t4_retire_tag", 32'(alloc_tag), 32'd0);
        chk("t4_retire_rd", 32'(commit_rd), 32'd1);
        cycle(1);
        alloc_valid  = 1'b0;
        chk("t4_refill_count", 32'(rob_count), 32'd16);
        chk("t4_refill_tag", 32'(alloc_tag), 32'd1);

        // Reset mid-run with five in-flight entries, one ready to retire.
        reset_dut();
        for (int i = 0; i < 5; i++) alloc(5'(i + 1), 6'(i + 1), 6'(10 + i));
        cmpl(4'd1);
        cmpl(4'd3);
        cmpl(4'd0);
        rst_n = 1'b0;
        #1;
        chk("t1_async_count", 32'(rob_count), 32'd0);
        chk("t1_async_commit", 32'(commit_valid), 32'd0);
        chk("t1_async_free", 32'(free_valid), 32'd0);
        chk("t1_async_rd", 32'(commit_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) cmpl(4'(i));
        for (int i = 0; i < 4; i++) begin
            cycle(1);
            chk("t1_no_commit", 32'(commit_valid), 32'd0);
            chk("t1_no_free", 32'(free_valid), 32'd0);
            chk("t1_count", 32'(rob_count), 32'd0);
        end

        cycle(2);
        chk("commits_drained", 32'(exp_q.size()), 32'd0);
        chk("frees_drained", 32'(free_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
